// File: rtl/lane_beam_combiner.sv
// Beam combiner for one lane: registered complex adder tree, round/shift/saturate
// stage, and a first-word-fall-through output FIFO with drop and saturation reporting.
module lane_beam_combiner #(
    parameter int NUM_CH     = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int SHIFT      = 8,
    parameter int BEAM_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH*2*OUT_WIDTH-1:0] mult_out_packed,
    input  logic                          mult_valid,
    output logic [BEAM_WIDTH-1:0]         beam_i,
    output logic [BEAM_WIDTH-1:0]         beam_q,
    output logic                          beam_valid,
    input  logic                          beam_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_count,
    output logic                          sat_flag,
    input  logic                          clear_flags
);

    localparam int T     = $clog2(NUM_CH);
    localparam int SUM_W = OUT_WIDTH + T;
    localparam int RND_W = SUM_W + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int NODES = NUM_CH - 1;

    localparam logic signed [RND_W-1:0] RND_ONE  = {{(RND_W-1){1'b0}}, 1'b1};
    localparam logic signed [RND_W-1:0] RND_HALF = RND_ONE <<< (SHIFT - 1);
    localparam logic signed [RND_W-1:0] BEAM_MAX = (RND_ONE <<< (BEAM_WIDTH - 1)) - RND_ONE;
    localparam logic signed [RND_W-1:0] BEAM_MIN = -(RND_ONE <<< (BEAM_WIDTH - 1));

    function automatic logic signed [SUM_W-1:0] sext(input logic [OUT_WIDTH-1:0] x);
        return {{T{x[OUT_WIDTH-1]}}, x};
    endfunction

    // Returns {clipped, value}: round half up, arithmetic shift, clamp to beam range.
    function automatic logic [BEAM_WIDTH:0] round_sat(input logic signed [SUM_W-1:0] s);
        logic signed [RND_W-1:0] r;
        logic signed [RND_W-1:0] sh;
        r  = $signed({s[SUM_W-1], s}) + RND_HALF;
        sh = r >>> SHIFT;
        if (sh > BEAM_MAX) begin
            return {1'b1, BEAM_MAX[BEAM_WIDTH-1:0]};
        end else if (sh < BEAM_MIN) begin
            return {1'b1, BEAM_MIN[BEAM_WIDTH-1:0]};
        end else begin
            return {1'b0, sh[BEAM_WIDTH-1:0]};
        end
    endfunction

    logic signed [SUM_W-1:0] leaf_i_s [NUM_CH];
    logic signed [SUM_W-1:0] leaf_q_s [NUM_CH];
    logic signed [SUM_W-1:0] node_i_r [NODES];
    logic signed [SUM_W-1:0] node_q_r [NODES];
    logic [T-1:0]            vld_sr_r;
    logic                    tree_valid_s;

    // Unpack and sign-extend each channel's product to the full sum width.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            leaf_i_s[ch] = sext(mult_out_packed[ch*2*OUT_WIDTH +: OUT_WIDTH]);
            leaf_q_s[ch] = sext(mult_out_packed[ch*2*OUT_WIDTH+OUT_WIDTH +: OUT_WIDTH]);
        end
    end

    // Heap-ordered tree: node k sums children 2k+1 and 2k+2; the bottom row reads the leaves.
    for (genvar k = 0; k < NODES; k++) begin : g_node
        if (k >= NUM_CH/2 - 1) begin : g_bottom
            // Bottom tree level registers pairs of channel products.
            always_ff @(posedge clk) begin
                node_i_r[k] <= leaf_i_s[2*k+2-NUM_CH] + leaf_i_s[2*k+3-NUM_CH];
                node_q_r[k] <= leaf_q_s[2*k+2-NUM_CH] + leaf_q_s[2*k+3-NUM_CH];
            end
        end else begin : g_inner
            // Inner tree level registers pairs of partial sums.
            always_ff @(posedge clk) begin
                node_i_r[k] <= node_i_r[2*k+1] + node_i_r[2*k+2];
                node_q_r[k] <= node_q_r[2*k+1] + node_q_r[2*k+2];
            end
        end
    end

    // Valid shift register tracking samples through the tree.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_r <= '0;
        end else begin
            vld_sr_r <= (vld_sr_r << 1) | T'(mult_valid);
        end
    end

    assign tree_valid_s = vld_sr_r[T-1];

    logic [BEAM_WIDTH:0]   rs_i_s;
    logic [BEAM_WIDTH:0]   rs_q_s;
    logic                  rnd_valid_r;
    logic [BEAM_WIDTH-1:0] rnd_i_r;
    logic [BEAM_WIDTH-1:0] rnd_q_r;

    // Round and saturate the tree root.
    always_comb begin
        rs_i_s = round_sat(node_i_r[0]);
        rs_q_s = round_sat(node_q_r[0]);
    end

    // Round stage valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_valid_r <= 1'b0;
        end else begin
            rnd_valid_r <= tree_valid_s;
        end
    end

    // Round stage data, loaded every cycle.
    always_ff @(posedge clk) begin
        rnd_i_r <= rs_i_s[BEAM_WIDTH-1:0];
        rnd_q_r <= rs_q_s[BEAM_WIDTH-1:0];
    end

    // Sticky saturation flag; a clip in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (tree_valid_s && (rs_i_s[BEAM_WIDTH] || rs_q_s[BEAM_WIDTH])) begin
            sat_flag <= 1'b1;
        end else if (clear_flags) begin
            sat_flag <= 1'b0;
        end
    end

    logic [BEAM_WIDTH-1:0] mem_i_r [FIFO_DEPTH];
    logic [BEAM_WIDTH-1:0] mem_q_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [LW-1:0]         level_r;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;

    // FIFO handshake decode: a pop frees the slot a same-cycle push needs.
    always_comb begin
        full_s = (level_r == LW'(FIFO_DEPTH));
        pop_s  = (level_r != '0) && beam_ready;
        push_s = rnd_valid_r && (!full_s || pop_s);
        drop_s = rnd_valid_r && full_s && !pop_s;
    end

    // FIFO storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < FIFO_DEPTH; n++) begin
                mem_i_r[n] <= '0;
                mem_q_r[n] <= '0;
            end
        end else if (push_s) begin
            mem_i_r[wr_ptr_r] <= rnd_i_r;
            mem_q_r[wr_ptr_r] <= rnd_q_r;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            level_r <= level_r + LW'(push_s) - LW'(pop_s);
        end
    end

    // Saturating drop counter; a drop in the same cycle as a clear counts as one.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= 16'd0;
        end else if (drop_s) begin
            if (clear_flags) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (clear_flags) begin
            drop_count <= 16'd0;
        end
    end

    assign beam_valid = (level_r != '0);
    assign beam_i     = mem_i_r[rd_ptr_r];
    assign beam_q     = mem_q_r[rd_ptr_r];
    assign fifo_level = level_r;

endmodule

// File: doc/lane_beam_combiner.md
# lane_beam_combiner

Downstream stage of the per-lane complex multiplier array. Sums the NUM_CH weighted complex products of one lane into a single beam sample through a registered adder tree, then rounds, right-shifts and saturates the result to the beam output width. Results go into a small output FIFO with a ready/valid interface to the next stage. The FIFO reports drops and saturation, because the multiplier path has no backpressure.

## Interface
Parameters:
- NUM_CH, `NUM_CH_PER_LANE (8): channels per lane; power of two, ≥2.
- OUT_WIDTH, `MULT_OUT_WIDTH (32): signed width of each real/imag product component.
- SHIFT, 8: arithmetic right shift applied after the sum; ≥1.
- BEAM_WIDTH, 24: signed width of each output component.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- mult_out_packed, input, NUM_CH*2*OUT_WIDTH: per channel ch, real at [ch*2*OUT_WIDTH +: OUT_WIDTH] and imag at [ch*2*OUT_WIDTH+OUT_WIDTH +: OUT_WIDTH], both signed.
- mult_valid, input, 1: mult_out_packed is valid this cycle; no backpressure.
- beam_i, output, BEAM_WIDTH: FIFO head, real part.
- beam_q, output, BEAM_WIDTH: FIFO head, imag part.
- beam_valid, output, 1: FIFO not empty.
- beam_ready, input, 1: consumer accepts the head when beam_valid && beam_ready.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: current occupancy.
- drop_count, output, 16: count of samples lost to a full FIFO; saturates at 16'hFFFF.
- sat_flag, output, 1: sticky; set when any output component clipped.
- clear_flags, input, 1: synchronous clear of drop_count and sat_flag.

## Operation
- Adder tree: T = log2(NUM_CH) registered levels. Each level sums pairs with 1-bit growth, so the final sum is OUT_WIDTH+T bits, exact, with no internal overflow. Real and imag trees are independent.
- Valid shift register runs alongside the tree. Data registers load every cycle. Only valid is reset.
- Round stage (1 register):
  - Add 2^(SHIFT-1) to the sum, then arithmetic shift right by SHIFT.
  - Clamp to [-2^(BEAM_WIDTH-1), 2^(BEAM_WIDTH-1)-1].
  - Clipping either component on a valid sample sets sat_flag.
- FIFO: circular buffer with first-word fall-through. The head is presented on beam_i/beam_q while beam_valid=1.
- Write when the round-stage output is valid:
  - If not full, or full with a pop in the same cycle: write is accepted.
  - If full with no pop: the sample is discarded and drop_count increments (saturating). FIFO contents are unchanged.
- Pop when beam_valid && beam_ready. A simultaneous push and pop on a non-empty FIFO leaves the level unchanged.
- Pop on an empty FIFO: ignored.
- clear_flags:
  - Zeroes drop_count and sat_flag.
  - If a drop or saturation occurs in the same cycle, that event wins: drop_count=1 and/or sat_flag=1.
- rst, at any time including mid-stream:
  - Clears the tree and round valid bits, FIFO pointers, level, drop_count and sat_flag.
  - In-flight samples are discarded.
  - beam_i/beam_q reset to 0.

## Timing
- Latency: mult_valid at cycle 0 → FIFO write at the end of cycle T+1 → beam_valid=1 in cycle T+2 if the FIFO was empty. This is cycle 5 for NUM_CH=8.
- Throughput: one sample per cycle, sustained, with mult_valid held high and beam_ready=1.
- beam_i/beam_q are stable while beam_valid=1 and beam_ready=0.
- fifo_level, drop_count and sat_flag update in the cycle after the causing edge; all are registered.
- Reset values: beam_valid=0, beam_i=0, beam_q=0, fifo_level=0, drop_count=0, sat_flag=0.
- The first valid input is accepted in the cycle after rst deasserts.

## Test plan
All scenarios use NUM_CH=8, OUT_WIDTH=32, SHIFT=8, BEAM_WIDTH=24, FIFO_DEPTH=4.
- Basic sum:
  - Stimulus: all channels real=256, imag=-256; one mult_valid pulse; beam_ready=1.
  - Response: in cycle 5, beam_valid=1, beam_i=8, beam_q=-8, for exactly one cycle.
- Rounding:
  - Stimulus: channel-sum real = 128, -128 and -129 (other channels 0) on three consecutive samples.
  - Response: beam_i = 1, 0, -1 in order; sat_flag stays 0.
- Saturation:
  - Stimulus: all real = 2^31-1, all imag = -2^31.
  - Response: beam_i=8388607, beam_q=-8388608, sat_flag=1. Then pulse clear_flags → sat_flag=0.
- Backpressure and drop:
  - Stimulus: beam_ready=0; 6 back-to-back valid samples with real = 256·k·8 for k=1..6.
  - Response: fifo_level=4, drop_count=2, head stable at beam_i=8.
  - Then: raise beam_ready → outputs 8, 16, 24, 32 in order, then beam_valid=0.
- Full push with pop:
  - Stimulus: FIFO full; a new sample arrives in the same cycle as a pop.
  - Response: no drop, fifo_level stays 4, order preserved.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle with 3 FIFO entries and 2 samples in the tree.
  - Response: next cycle beam_valid=0, fifo_level=0, drop_count=0; no stale sample appears afterward.
